// File: rtl/jesd204_tx_link_ctrl.sv
// JESD204 TX link bring-up and recovery sequencer (device-clock domain).
//
// Walks IDLE -> PHY_RST -> WAIT_PHY -> TX_START -> LINK. It releases the PHY
// reset first, then the tx datapath reset. From LINK it falls back to
// TX_START on a debounced SYNC~ request or when RDY is lost. It returns to
// PHY_RST when the PHY drops out or when PHY_RST_DONE times out.
//
// Ports:
//   clk_i           device clock, rising edge
//   rst_ni          asynchronous active-low reset
//   en_i            link enable (level)
//   phy_rst_done_i  PHY reset complete (level)
//   sync_n_i        JESD SYNC~ from the receiver
//   rdy_i           tx datapath is in the data phase
//   err_clr_i       single-cycle pulse; clears resync_cnt_o and timeout_err_o
//   phy_rst_o       PHY reset request, active-high
//   tx_rst_n_o      tx datapath reset, active-low
//   link_up_o       high only in LINK
//   state_o         current state encoding (0..4)
//   resync_cnt_o    saturating count of qualified resync events
//   timeout_err_o   sticky PHY reset timeout flag
module jesd204_tx_link_ctrl #(
    parameter int unsigned PHY_RST_CYCLES = 16,
    parameter int unsigned PHY_TIMEOUT    = 65535,
    parameter int unsigned SYNC_DEB       = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       phy_rst_done_i,
    input  logic       sync_n_i,
    input  logic       rdy_i,
    input  logic       err_clr_i,
    output logic       phy_rst_o,
    output logic       tx_rst_n_o,
    output logic       link_up_o,
    output logic [2:0] state_o,
    output logic [7:0] resync_cnt_o,
    output logic       timeout_err_o
);

    localparam int unsigned TmrW = $clog2(PHY_TIMEOUT + 1);
    localparam int unsigned RstW = $clog2(PHY_RST_CYCLES + 1);
    // The phase counter times both PHY_RST and WAIT_PHY, so size it for the longer one.
    localparam int unsigned CntW = (TmrW > RstW) ? TmrW : RstW;
    localparam int unsigned DebW = $clog2(SYNC_DEB + 1);

    localparam logic [CntW-1:0] RstLast = CntW'(PHY_RST_CYCLES - 1);
    localparam logic [CntW-1:0] TmoLast = CntW'(PHY_TIMEOUT - 1);
    localparam logic [DebW-1:0] DebLast = DebW'(SYNC_DEB - 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPhyRst  = 3'd1,
        StWaitPhy = 3'd2,
        StTxStart = 3'd3,
        StLink    = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DebW-1:0] deb_q, deb_d;
    logic [7:0]      resync_q, resync_d;
    logic            terr_q, terr_d;
    logic            phy_rst_q, phy_rst_d;
    logic            tx_rst_n_q, tx_rst_n_d;
    logic            link_up_q, link_up_d;
    logic            resync_evt, timeout_evt;

    // Next-state logic. Counters default to 0 so that every state entry
    // (and any exit from LINK) starts them from a clean value.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        deb_d       = '0;
        resync_evt  = 1'b0;
        timeout_evt = 1'b0;

        if (state_q != StIdle && !en_i) begin
            state_d = StIdle;
        end else if ((state_q == StTxStart || state_q == StLink) && !phy_rst_done_i) begin
            // PHY lost: redo the whole reset sequence.
            state_d = StPhyRst;
        end else begin
            case (state_q)
                StIdle: begin
                    if (en_i) state_d = StPhyRst;
                end
                StPhyRst: begin
                    if (cnt_q == RstLast) state_d = StWaitPhy;
                    else                  cnt_d   = cnt_q + 1'b1;
                end
                StWaitPhy: begin
                    if (phy_rst_done_i) begin
                        state_d = StTxStart;
                    end else if (cnt_q == TmoLast) begin
                        state_d     = StPhyRst;
                        timeout_evt = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StTxStart: begin
                    if (rdy_i) state_d = StLink;
                end
                StLink: begin
                    // A qualified SYNC~ request outranks a plain loss of RDY.
                    if (!sync_n_i && deb_q == DebLast) begin
                        state_d    = StTxStart;
                        resync_evt = 1'b1;
                    end else if (!rdy_i) begin
                        state_d = StTxStart;
                    end else if (!sync_n_i) begin
                        deb_d = deb_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Error bookkeeping; a clear pulse drops any event in the same cycle.
    always_comb begin
        resync_d = resync_q;
        terr_d   = terr_q;
        if (err_clr_i) begin
            resync_d = '0;
            terr_d   = 1'b0;
        end else begin
            if (resync_evt && resync_q != 8'hff) resync_d = resync_q + 8'd1;
            if (timeout_evt)                     terr_d   = 1'b1;
        end
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with state_q and carry no combinational glitches.
    always_comb begin
        phy_rst_d  = (state_d == StIdle) || (state_d == StPhyRst);
        tx_rst_n_d = (state_d == StTxStart) || (state_d == StLink);
        link_up_d  = (state_d == StLink);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            deb_q      <= '0;
            resync_q   <= '0;
            terr_q     <= 1'b0;
            phy_rst_q  <= 1'b1;
            tx_rst_n_q <= 1'b0;
            link_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            resync_q   <= resync_d;
            terr_q     <= terr_d;
            phy_rst_q  <= phy_rst_d;
            tx_rst_n_q <= tx_rst_n_d;
            link_up_q  <= link_up_d;
        end
    end

    assign state_o       = state_q;
    assign phy_rst_o     = phy_rst_q;
    assign tx_rst_n_o    = tx_rst_n_q;
    assign link_up_o     = link_up_q;
    assign resync_cnt_o  = resync_q;
    assign timeout_err_o = terr_q;

endmodule
